coeff_ram_ctrl: RTL

COEFF_RAM_CTRL -- requirements
Module: coeff_ram_ctrl

---
 rtl/coeff_ram_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/coeff_ram_ctrl.sv
// Coefficient RAM controller: loads P_TAPS coefficients from a host into an external
// single-port RAM and streams them back, one per cycle, for each new sample.
module coeff_ram_ctrl #(
  parameter int P_TAPS = 10,
  parameter int P_DW   = 16,
  parameter int P_AW   = 4
) (
  input  logic            iClk_12M,
  input  logic            iRsn,
  input  logic            iCoeffUpdate,
  input  logic            iCoeffWrEn,
  input  logic [P_DW-1:0] iCoeffWrDt,
  input  logic            iEnSample,
  output logic            oCsnRam,
  output logic            oWrnRam,
  output logic [P_AW-1:0] oAddrRam,
  output logic [P_DW-1:0] oWrDtRam,
  input  logic [P_DW-1:0] iRdDtRam,
  output logic [P_DW-1:0] oCoeff,
  output logic            oCoeffValid,
  output logic [P_AW-1:0] oCoeffIdx,
  output logic            oCoeffLast,
  output logic            oUpdDone,
  output logic            oSampleDrop,
  output logic            oBusy
);

  localparam logic [P_AW-1:0] LAST_IDX = P_AW'(P_TAPS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t          state_q;
  logic [P_AW-1:0] wr_cnt_q;
  logic [P_AW-1:0] rd_cnt_q;
  logic            valid_q;
  logic [P_AW-1:0] idx_q;
  logic            last_q;
  logic            upd_done_q;
  logic            drop_q;

  logic wr_fire;
  logic rd_fire;

  assign wr_fire = (state_q == WRITE) && iCoeffWrEn;
  assign rd_fire = (state_q == READ);

  // The write strobe must reach the RAM in the same cycle the host presents the data,
  // so the RAM port is decoded combinationally from state and the host strobe.
  // NOTE: every output gets its idle value first, so no path through this block can infer a latch.
  always_comb begin
    oCsnRam  = 1'b1;
    oWrnRam  = 1'b1;
    oAddrRam = '0;
    oWrDtRam = '0;
    if (wr_fire) begin
      oCsnRam  = 1'b0;
      oWrnRam  = 1'b0;
      oAddrRam = wr_cnt_q;
      oWrDtRam = iCoeffWrDt;
    end else if (rd_fire) begin
      oCsnRam  = 1'b0;
      oAddrRam = rd_cnt_q;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // The RAM itself is external; only control state is reset here, its contents survive.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      upd_done_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      upd_done_q <= 1'b0;
      drop_q     <= 1'b0;
      valid_q    <= rd_fire;
      idx_q      <= rd_fire ? rd_cnt_q : '0;
      last_q     <= rd_fire && (rd_cnt_q == LAST_IDX);

      case (state_q)
        IDLE: begin
          if (iCoeffUpdate) begin
            state_q  <= WRITE;
            wr_cnt_q <= '0;
            drop_q   <= iEnSample;
          end else if (iEnSample) begin
            state_q  <= READ;
            rd_cnt_q <= '0;
          end
        end
        WRITE: begin
          drop_q <= iEnSample;
          if (wr_fire && (wr_cnt_q == LAST_IDX)) begin
            upd_done_q <= 1'b1;
            state_q    <= IDLE;
            wr_cnt_q   <= '0;
          end else if (!iCoeffUpdate) begin
            state_q  <= IDLE;
            wr_cnt_q <= '0;
          end else if (iCoeffWrEn) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
          end
        end
        READ: begin
          // A pending reload request simply waits here; IDLE picks it up after the sweep.
          drop_q <= iEnSample;
          if (rd_cnt_q == LAST_IDX) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
          end else begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oCoeff      = iRdDtRam;
  assign oCoeffValid = valid_q;
  assign oCoeffIdx   = idx_q;
  assign oCoeffLast  = last_q;
  assign oUpdDone    = upd_done_q;
  assign oSampleDrop = drop_q;
  assign oBusy       = (state_q != IDLE) || valid_q;

endmodule
